pipe_controller: RTL and testbench
==================================

// Module: pipe_controller
// PURPOSE
//  Pipelined MIPS control unit: decodes op/funct in the Decode stage and carries
//  the control word through the ID/EX, EX/MEM and MEM/WB registers alongside the datapath.
//  Adds BNE, ANDI, ORI and SLTI to the base R-type/LW/SW/BEQ/ADDI/J set.
//  Adds a parametrised ALU-control width, a pipeline freeze and a bubble-safe decode.
//  Sits between the instruction register (IF/ID) and the pipelined datapath; the hazard unit drives flush_e/hold.
// PARAMETERS
//  ALUC_W   3  alucontrol width; >=3; bits above [2:0] are always 0
//  EXT_ISA  1  1: decode BNE/ANDI/ORI/SLTI; 0: those opcodes decode as unknown
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high; clears all stage registers
//  op_d         in   6       opcode of instruction in Decode
//  funct_d      in   6       funct field of instruction in Decode
//  flush_e      in   1       load a bubble (all-zero controls) into ID/EX at next edge
//  hold         in   1       freeze ID/EX, EX/MEM and MEM/WB (memory stall)
//  branch_d     out  1       BEQ in Decode (comb)
//  bne_d        out  1       BNE in Decode (comb)
//  jump_d       out  1       J in Decode (comb)
//  zeroext_d    out  1       ANDI/ORI: zero-extend immediate (comb)
//  regwrite_e   out  1       } ID/EX controls
//  regdst_e     out  1       }
//  alusrc_e     out  1       }
//  memtoreg_e   out  1       }
//  memwrite_e   out  1       }
//  alucontrol_e out  ALUC_W  }
//  regwrite_m   out  1       } EX/MEM controls
//  memtoreg_m   out  1       }
//  memwrite_m   out  1       }
//  regwrite_w   out  1       } MEM/WB controls
//  memtoreg_w   out  1       }
//  illegal_w    out  1       illegal instruction reached WB (see CONFIGURATION)
// BEHAVIOUR
//  - Decode is combinational. Controls reach the _e outputs 1 clock after Decode, _m after 2, _w after 3.
//  - Main decode {regwrite,regdst,alusrc,memwrite,memtoreg}; ALU class -> alucontrol:
//    R 11000 funct | LW 10101 add | SW 00110 add | BEQ/BNE 00000 sub | ADDI 10100 add
//    ANDI 10100 and | ORI 10100 or | SLTI 10100 slt | J 00000 (jump_d=1).
//  - funct: 100000 ADD=010, 100010 SUB=110, 100100 AND=000, 100101 OR=001, 101010 SLT=111.
//  - Unknown op, or R-type with unknown funct: every control 0 (bubble) and alucontrol 0. Never X.
//  - Stage registers are plain flops. Reset clears all of them: every _e/_m/_w output is 0 and illegal_w is 0.
//  - Per edge, highest priority first:
//    1. reset: clear all stage registers.
//    2. hold: all three stage registers keep their value.
//    3. flush_e: ID/EX <= 0; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
//    4. otherwise: all three stage registers shift.
//  - hold with flush_e: hold wins and the flush is not remembered; the hazard unit re-asserts flush_e.
//  - Reset mid-instruction discards all in-flight controls.
//    The first post-reset edge loads the current decode into ID/EX.
//  - The _d outputs ignore hold, flush_e and reset; they follow op_d/funct_d only.
// CONFIGURATION
//  PIPE_CTRL_ILLEGAL_EN defined:
//    - An unknown op or funct sets an illegal bit carried through ID/EX -> EX/MEM -> MEM/WB.
//    - The bit obeys hold, flush and reset like the other controls. illegal_w = MEM/WB bit.
//    - A flushed illegal instruction never reaches illegal_w.
//  PIPE_CTRL_ILLEGAL_EN undefined: illegal_w tied 0 and no flop is generated. Bubble decode is unchanged.
// TESTING
//  1. Reset high then low; op_d=000000, funct_d=100000 -> edge1 regwrite_e=1, regdst_e=1, alucontrol_e=010;
//     edge2 regwrite_m=1; edge3 regwrite_w=1.
//  2. LW (100011) then SW (101011) back to back -> memtoreg_w=1 at edge3;
//     memwrite_m=1 at edge3 with regwrite_m=0.
//  3. BEQ / BNE / ORI in Decode -> branch_d=1 / bne_d=1 / zeroext_d=1 (comb);
//     ORI gives alucontrol_e=001, alusrc_e=1. With EXT_ISA=0, ORI gives all-zero controls.
//  4. ADD in Decode with flush_e=1 -> all _e outputs 0 after the edge;
//     the preceding LW still gives memtoreg_m=1.
//  5. hold=1 for 3 cycles with LW in EX/MEM and flush_e=1 -> all stage outputs unchanged.
//     hold=0 -> pipeline resumes; the flush is dropped.
//  6. op_d=111111 with macro defined -> illegal_w=1 exactly 3 edges later, regwrite_w=0.
//     Async reset asserted mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_controller.sv
// Pipelined MIPS control unit: combinational decode plus ID/EX, EX/MEM and MEM/WB control registers.
// Define PIPE_CTRL_ILLEGAL_EN to carry an illegal-instruction bit through to illegal_w.
module pipe_controller #(
    parameter int unsigned ALUC_W  = 3,
    parameter int unsigned EXT_ISA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op_d,
    input  logic [5:0]        funct_d,
    input  logic              flush_e,
    input  logic              hold,
    output logic              branch_d,
    output logic              bne_d,
    output logic              jump_d,
    output logic              zeroext_d,
    output logic              regwrite_e,
    output logic              regdst_e,
    output logic              alusrc_e,
    output logic              memtoreg_e,
    output logic              memwrite_e,
    output logic [ALUC_W-1:0] alucontrol_e,
    output logic              regwrite_m,
    output logic              memtoreg_m,
    output logic              memwrite_m,
    output logic              regwrite_w,
    output logic              memtoreg_w,
    output logic              illegal_w
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_SLTI  = 6'b001010,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_SLT = 6'b101010
    } funct_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } aluop_e;

    logic              w_valid;
    logic [4:0]        w_ctl;
    aluop_e            w_alu;
    logic              w_regwrite;
    logic              w_regdst;
    logic              w_alusrc;
    logic              w_memwrite;
    logic              w_memtoreg;
    logic [ALUC_W-1:0] w_aluc;

    logic              r_regwrite_e;
    logic              r_regdst_e;
    logic              r_alusrc_e;
    logic              r_memtoreg_e;
    logic              r_memwrite_e;
    logic [ALUC_W-1:0] r_aluc_e;
    logic              r_regwrite_m;
    logic              r_memtoreg_m;
    logic              r_memwrite_m;
    logic              r_regwrite_w;
    logic              r_memtoreg_w;

    // w_ctl = {regwrite, regdst, alusrc, memwrite, memtoreg}
    always_comb begin
        w_valid   = 1'b0;
        w_ctl     = '0;
        w_alu     = ALU_AND;
        branch_d  = 1'b0;
        bne_d     = 1'b0;
        jump_d    = 1'b0;
        zeroext_d = 1'b0;
        case (op_d)
            OP_RTYPE: begin
                w_ctl   = 5'b11000;
                w_valid = 1'b1;
                case (funct_d)
                    FN_ADD:  w_alu = ALU_ADD;
                    FN_SUB:  w_alu = ALU_SUB;
                    FN_AND:  w_alu = ALU_AND;
                    FN_OR:   w_alu = ALU_OR;
                    FN_SLT:  w_alu = ALU_SLT;
                    default: w_valid = 1'b0;
                endcase
            end
            OP_LW:   begin w_valid = 1'b1; w_ctl = 5'b10101; w_alu = ALU_ADD; end
            OP_SW:   begin w_valid = 1'b1; w_ctl = 5'b00110; w_alu = ALU_ADD; end
            OP_BEQ:  begin w_valid = 1'b1; w_alu = ALU_SUB; branch_d = 1'b1; end
            OP_ADDI: begin w_valid = 1'b1; w_ctl = 5'b10100; w_alu = ALU_ADD; end
            OP_J:    begin w_valid = 1'b1; jump_d = 1'b1; end
            OP_BNE: begin
                if (EXT_ISA != 0) begin
                    w_valid = 1'b1; w_alu = ALU_SUB; bne_d = 1'b1;
                end
            end
            OP_ANDI: begin
                if (EXT_ISA != 0) begin
                    w_valid = 1'b1; w_ctl = 5'b10100; w_alu = ALU_AND; zeroext_d = 1'b1;
                end
            end
            OP_ORI: begin
                if (EXT_ISA != 0) begin
                    w_valid = 1'b1; w_ctl = 5'b10100; w_alu = ALU_OR; zeroext_d = 1'b1;
                end
            end
            OP_SLTI: begin
                if (EXT_ISA != 0) begin
                    w_valid = 1'b1; w_ctl = 5'b10100; w_alu = ALU_SLT;
                end
            end
            default: ;
        endcase
    end

    // Unknown R-type funct leaves w_ctl populated, so every control is gated by w_valid.
    always_comb begin
        w_regwrite = w_valid & w_ctl[4];
        w_regdst   = w_valid & w_ctl[3];
        w_alusrc   = w_valid & w_ctl[2];
        w_memwrite = w_valid & w_ctl[1];
        w_memtoreg = w_valid & w_ctl[0];
        w_aluc     = '0;
        if (w_valid) begin
            w_aluc[2:0] = w_alu;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite_e <= 1'b0;
            r_regdst_e   <= 1'b0;
            r_alusrc_e   <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_memwrite_e <= 1'b0;
            r_aluc_e     <= '0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else if (!hold) begin
            if (flush_e) begin
                r_regwrite_e <= 1'b0;
                r_regdst_e   <= 1'b0;
                r_alusrc_e   <= 1'b0;
                r_memtoreg_e <= 1'b0;
                r_memwrite_e <= 1'b0;
                r_aluc_e     <= '0;
            end else begin
                r_regwrite_e <= w_regwrite;
                r_regdst_e   <= w_regdst;
                r_alusrc_e   <= w_alusrc;
                r_memtoreg_e <= w_memtoreg;
                r_memwrite_e <= w_memwrite;
                r_aluc_e     <= w_aluc;
            end
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_memwrite_m <= r_memwrite_e;
            r_regwrite_w <= r_regwrite_m;
            r_memtoreg_w <= r_memtoreg_m;
        end
    end

`ifdef PIPE_CTRL_ILLEGAL_EN
    logic r_ill_e;
    logic r_ill_m;
    logic r_ill_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ill_e <= 1'b0;
            r_ill_m <= 1'b0;
            r_ill_w <= 1'b0;
        end else if (!hold) begin
            r_ill_e <= flush_e ? 1'b0 : !w_valid;
            r_ill_m <= r_ill_e;
            r_ill_w <= r_ill_m;
        end
    end

    assign illegal_w = r_ill_w;
`else
    assign illegal_w = 1'b0;
`endif

    assign regwrite_e   = r_regwrite_e;
    assign regdst_e     = r_regdst_e;
    assign alusrc_e     = r_alusrc_e;
    assign memtoreg_e   = r_memtoreg_e;
    assign memwrite_e   = r_memwrite_e;
    assign alucontrol_e = r_aluc_e;
    assign regwrite_m   = r_regwrite_m;
    assign memtoreg_m   = r_memtoreg_m;
    assign memwrite_m   = r_memwrite_m;
    assign regwrite_w   = r_regwrite_w;
    assign memtoreg_w   = r_memtoreg_w;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: hand-computed control words per edge, plus an EXT_ISA=0/ALUC_W=4 instance.
// Illegal-bit expectations apply only when PIPE_CTRL_ILLEGAL_EN is defined.
module tb_pipe_controller;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000;
    localparam logic [5:0] FSUB = 6'b100010;
    localparam logic [5:0] FAND = 6'b100100;
    localparam logic [5:0] FOR  = 6'b100101;
    localparam logic [5:0] FSLT = 6'b101010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_d;
    logic [5:0] funct_d;
    logic       flush_e;
    logic       hold;

    logic       branch_d, bne_d, jump_d, zeroext_d;
    logic       regwrite_e, regdst_e, alusrc_e, memtoreg_e, memwrite_e;
    logic [2:0] alucontrol_e;
    logic       regwrite_m, memtoreg_m, memwrite_m;
    logic       regwrite_w, memtoreg_w, illegal_w;

    logic       x_branch_d, x_bne_d, x_jump_d, x_zeroext_d;
    logic       x_regwrite_e, x_regdst_e, x_alusrc_e, x_memtoreg_e, x_memwrite_e;
    logic [3:0] x_alucontrol_e;
    logic       x_regwrite_m, x_memtoreg_m, x_memwrite_m;
    logic       x_regwrite_w, x_memtoreg_w, x_illegal_w;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned row     = 0;

    always #5 clk = ~clk;

    pipe_controller #(.ALUC_W(3), .EXT_ISA(1)) dut (
        .clk(clk), .reset(reset), .op_d(op_d), .funct_d(funct_d),
        .flush_e(flush_e), .hold(hold),
        .branch_d(branch_d), .bne_d(bne_d), .jump_d(jump_d), .zeroext_d(zeroext_d),
        .regwrite_e(regwrite_e), .regdst_e(regdst_e), .alusrc_e(alusrc_e),
        .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e), .alucontrol_e(alucontrol_e),
        .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
        .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w), .illegal_w(illegal_w)
    );

    pipe_controller #(.ALUC_W(4), .EXT_ISA(0)) dut_x (
        .clk(clk), .reset(reset), .op_d(op_d), .funct_d(funct_d),
        .flush_e(flush_e), .hold(hold),
        .branch_d(x_branch_d), .bne_d(x_bne_d), .jump_d(x_jump_d), .zeroext_d(x_zeroext_d),
        .regwrite_e(x_regwrite_e), .regdst_e(x_regdst_e), .alusrc_e(x_alusrc_e),
        .memtoreg_e(x_memtoreg_e), .memwrite_e(x_memwrite_e), .alucontrol_e(x_alucontrol_e),
        .regwrite_m(x_regwrite_m), .memtoreg_m(x_memtoreg_m), .memwrite_m(x_memwrite_m),
        .regwrite_w(x_regwrite_w), .memtoreg_w(x_memtoreg_w), .illegal_w(x_illegal_w)
    );

    // Packed views: d={branch,bne,jump,zeroext}, e={rw,rd,as,mw,mt,aluc}, m={rw,mw,mt}, w={rw,mt}
    logic [3:0] v_d;
    logic [7:0] v_e;
    logic [2:0] v_m;
    logic [1:0] v_w;
    logic [8:0] v_xe;
    assign v_d  = {branch_d, bne_d, jump_d, zeroext_d};
    assign v_e  = {regwrite_e, regdst_e, alusrc_e, memwrite_e, memtoreg_e, alucontrol_e};
    assign v_m  = {regwrite_m, memwrite_m, memtoreg_m};
    assign v_w  = {regwrite_w, memtoreg_w};
    assign v_xe = {x_regwrite_e, x_regdst_e, x_alusrc_e, x_memwrite_e, x_memtoreg_e, x_alucontrol_e};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", tag, row, got, exp);
        end
    endtask

    task automatic check_ill(input string tag, input logic exp);
`ifdef PIPE_CTRL_ILLEGAL_EN
        check(tag, {31'd0, illegal_w}, {31'd0, exp});
`else
        check(tag, {31'd0, illegal_w}, 32'd0);
`endif
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic fl, input logic h,
                        input logic [3:0] d, input logic [7:0] e, input logic [2:0] m,
                        input logic [1:0] w, input logic ill);
        row++;
        op_d = op; funct_d = fn; flush_e = fl; hold = h;
        #1;
        check("decode_d", {28'd0, v_d}, {28'd0, d});
        @(posedge clk);
        #1;
        check("ctrl_e", {24'd0, v_e}, {24'd0, e});
        check("ctrl_m", {29'd0, v_m}, {29'd0, m});
        check("ctrl_w", {30'd0, v_w}, {30'd0, w});
        check_ill("illegal_w", ill);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {19'd0, v_e, v_m, v_w}, 32'd0);
        check_ill({tag, "_ill"}, 1'b0);
    endtask

    initial begin
        reset = 1'b1; op_d = BEQ; funct_d = 6'd0; flush_e = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        check("reset_branch_d", {31'd0, branch_d}, 32'd1);
        op_d = J;
        reset = 1'b0;

        //   op    funct flush hold d        e             m       w      ill
        step(R,    FADD, 0, 0, 4'b0000, 8'b11000_010, 3'b000, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b100, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b10, 0);
        step(LW,   0,    0, 0, 4'b0000, 8'b10101_010, 3'b000, 2'b00, 0);
        step(SW,   0,    0, 0, 4'b0000, 8'b00110_010, 3'b101, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b010, 2'b11, 0);
        step(ORI,  0,    0, 0, 4'b0001, 8'b10100_001, 3'b000, 2'b00, 0);
        step(BEQ,  0,    0, 0, 4'b1000, 8'b00000_110, 3'b100, 2'b00, 0);
        step(BNE,  0,    0, 0, 4'b0100, 8'b00000_110, 3'b000, 2'b10, 0);
        step(ANDI, 0,    0, 0, 4'b0001, 8'b10100_000, 3'b000, 2'b00, 0);
        step(SLTI, 0,    0, 0, 4'b0000, 8'b10100_111, 3'b100, 2'b00, 0);
        step(R,    FSUB, 0, 0, 4'b0000, 8'b11000_110, 3'b100, 2'b10, 0);
        step(R,    FAND, 0, 0, 4'b0000, 8'b11000_000, 3'b100, 2'b10, 0);
        step(R,    FOR,  0, 0, 4'b0000, 8'b11000_001, 3'b100, 2'b10, 0);
        step(R,    FSLT, 0, 0, 4'b0000, 8'b11000_111, 3'b100, 2'b10, 0);
        step(ADDI, 0,    0, 0, 4'b0000, 8'b10100_010, 3'b100, 2'b10, 0);
        step(R,    BAD,  0, 0, 4'b0000, 8'b00000_000, 3'b100, 2'b10, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b10, 0);
        step(LW,   0,    0, 0, 4'b0000, 8'b10101_010, 3'b000, 2'b00, 1);
        step(R,    FADD, 1, 0, 4'b0000, 8'b00000_000, 3'b101, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b11, 0);
        step(LW,   0,    0, 0, 4'b0000, 8'b10101_010, 3'b000, 2'b00, 0);
        step(SW,   0,    0, 0, 4'b0000, 8'b00110_010, 3'b101, 2'b00, 0);
        step(R,    FADD, 1, 1, 4'b0000, 8'b00110_010, 3'b101, 2'b00, 0);
        step(R,    FADD, 1, 1, 4'b0000, 8'b00110_010, 3'b101, 2'b00, 0);
        step(R,    FADD, 1, 1, 4'b0000, 8'b00110_010, 3'b101, 2'b00, 0);
        step(R,    FADD, 0, 0, 4'b0000, 8'b11000_010, 3'b010, 2'b11, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b100, 2'b00, 0);
        step(BAD,  0,    0, 0, 4'b0000, 8'b00000_000, 3'b000, 2'b10, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b00, 1);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b00, 0);
        step(BAD,  0,    1, 0, 4'b0000, 8'b00000_000, 3'b000, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b00, 0);

        // Fill the pipe with ADD/illegal, then assert reset asynchronously mid-cycle.
        step(R,    FADD, 0, 0, 4'b0000, 8'b11000_010, 3'b000, 2'b00, 0);
        step(BAD,  0,    0, 0, 4'b0000, 8'b00000_000, 3'b100, 2'b00, 0);
        op_d = R; funct_d = FADD;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(R,    FADD, 0, 0, 4'b0000, 8'b11000_010, 3'b000, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b100, 2'b00, 0);
        step(J,    0,    0, 0, 4'b0010, 8'b00000_000, 3'b000, 2'b10, 0);

        // EXT_ISA=0, ALUC_W=4 instance: extension opcodes decode as bubbles.
        row++;
        op_d = ORI; funct_d = 6'd0; flush_e = 1'b0; hold = 1'b0;
        #1;
        check("x_zeroext_d", {31'd0, x_zeroext_d}, 32'd0);
        @(posedge clk);
        #1;
        check("x_ori_e", {23'd0, v_xe}, 32'd0);
        op_d = BNE;
        #1;
        check("x_bne_d", {31'd0, x_bne_d}, 32'd0);
        @(posedge clk);
        #1;
        check("x_bne_e", {23'd0, v_xe}, 32'd0);
        op_d = R; funct_d = FSLT;
        @(posedge clk);
        #1;
        check("x_slt_e", {23'd0, v_xe}, {23'd0, 9'b11000_0111});
        op_d = LW;
        @(posedge clk);
        #1;
        check("x_lw_e", {23'd0, v_xe}, {23'd0, 9'b10101_0010});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary, expected completion");
        $fatal(1);
    end

endmodule
